// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe -- pipelined lower-part-OR approximate adder.
//
// The low APPROX_BITS of the sum are the bitwise OR of the operand LSBs.
// The upper part is an exact add, with a carry-in guessed from the top
// approximated bit pair. The sum is formed in the first stage. The remaining
// stages are an elastic valid/ready carry chain of STAGES entries in total.
//
// Optional feature: define APPROX_ERR_MONITOR_EN to compile in the runtime
// error monitor (exact adder, per-result error, err_count/err_max/err_clr).
// Without it, err_count/err_max read 0, err_clr is ignored, and the datapath
// is identical.

// One elastic stage: a valid bit plus a payload register.
module approx_adder_pipe_stage #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          vld,
    output logic [DW-1:0] data
);

    // The payload is captured only for a real item, so a drained stage keeps
    // showing its last value instead of bubble garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld <= in_vld;
            if (in_vld)
                data <= in_data;
        end
    end

endmodule

module approx_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int STAGES      = 2,
    parameter int ET          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [15:0]      err_count,
    output logic [WIDTH:0]   err_max
);

    localparam int K  = APPROX_BITS;
    localparam int SW = WIDTH + 1;       // sum width
    localparam int HW = WIDTH - K + 1;   // exact upper-part width incl. carry out
`ifdef APPROX_ERR_MONITOR_EN
    localparam int DW = 3 * SW;          // {err, exact, approx}
`else
    localparam int DW = SW;              // {approx}
`endif

    // vld_pipe[0]/dat_pipe[0] is the incoming item; index i+1 is stage i.
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][DW-1:0] dat_pipe;
    logic [STAGES-1:0]       load;

    // ---------------------------------------------------------------
    // First-stage arithmetic
    // ---------------------------------------------------------------
    logic [K-1:0]  sum_low;
    logic          sum_cin;
    logic [HW-1:0] sum_high;
    logic [SW-1:0] sum_approx;

    // Lower-part OR, carry guessed from the top approximated bit pair.
    always_comb begin
        sum_low    = in_a[K-1:0] | in_b[K-1:0];
        sum_cin    = in_a[K-1] & in_b[K-1];
        sum_high   = HW'(in_a[WIDTH-1:K]) + HW'(in_b[WIDTH-1:K]) + HW'(sum_cin);
        sum_approx = {sum_high, sum_low};
    end

`ifdef APPROX_ERR_MONITOR_EN
    logic [SW-1:0] sum_exact;
    logic [SW-1:0] sum_err;

    // Exact reference and absolute error, carried alongside the result.
    always_comb begin
        sum_exact = SW'(in_a) + SW'(in_b);
        if (sum_exact >= sum_approx)
            sum_err = sum_exact - sum_approx;
        else
            sum_err = sum_approx - sum_exact;
    end

    assign dat_pipe[0] = {sum_err, sum_exact, sum_approx};
`else
    assign dat_pipe[0] = sum_approx;
`endif

    assign vld_pipe[0] = in_valid;

    // ---------------------------------------------------------------
    // Elastic control
    // ---------------------------------------------------------------
    // A stage loads when empty or when the next one takes its item this cycle.
    // Walking back from the output makes a full pipe stall in the same cycle
    // as out_ready drops, and lets a full pipe accept while it delivers.
    always_comb begin
        logic ld;
        ld   = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ld      = ~vld_pipe[i+1] | ld;
            load[i] = ld;
        end
    end

    assign in_ready = load[0] & ~rst;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            approx_adder_pipe_stage #(.DW(DW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load    (load[g]),
                .in_vld  (vld_pipe[g]),
                .in_data (dat_pipe[g]),
                .vld     (vld_pipe[g+1]),
                .data    (dat_pipe[g+1])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[STAGES];
    assign out_sum   = dat_pipe[STAGES][SW-1:0];

    // ---------------------------------------------------------------
    // Error monitor
    // ---------------------------------------------------------------
`ifdef APPROX_ERR_MONITOR_EN
    logic          deliver;
    logic [SW-1:0] out_err;
    logic [SW-1:0] unused_exact;
    logic [15:0]   cnt_q;
    logic [SW-1:0] max_q;

    assign deliver      = vld_pipe[STAGES] & out_ready;
    assign out_err      = dat_pipe[STAGES][3*SW-1:2*SW];
    assign unused_exact = dat_pipe[STAGES][2*SW-1:SW];

    // Statistics update on delivery; a clear beats a coinciding sample.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            cnt_q <= '0;
            max_q <= '0;
        end else if (deliver) begin
            if (out_err > SW'(ET) && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
            if (out_err > max_q)
                max_q <= out_err;
        end
    end

    assign err_count = cnt_q;
    assign err_max   = max_q;
`else
    logic unused_clr;
    assign unused_clr = err_clr;
    assign err_count  = '0;
    assign err_max    = '0;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe (WIDTH=8, k=2, STAGES=2, ET=1).
// Expectations for the statistics follow the build: with the monitor macro
// they are the hand-computed values, otherwise 0.
module tb_approx_adder_pipe;

`ifdef APPROX_ERR_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_a, in_b;
    logic        in_valid, in_ready;
    logic [8:0]  out_sum;
    logic        out_valid, out_ready;
    logic        err_clr;
    logic [15:0] err_count;
    logic [8:0]  err_max;

    int n_chk = 0;
    int n_fail = 0;

    approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2), .ET(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count),
        .err_max   (err_max)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_sum !== 9'h000) begin n_fail++; $display("FAIL reset_out_sum: got %h want 000", out_sum); end
        n_chk++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count: got %h want 0", err_count); end
        n_chk++; if (err_max !== 9'h0) begin n_fail++; $display("FAIL reset_err_max: got %h want 0", err_max); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_a = 8'h03; in_b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_chk++; if (out_sum !== 9'h003) begin n_fail++; $display("FAIL single_sum: got %h want 003", out_sum); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_dup: got %b want 0", out_valid); end
        n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL single_err_count: got %h want 0", err_count); end
        n_chk++; if (err_max !== (MON ? 9'd1 : 9'd0)) begin n_fail++; $display("FAIL single_err_max: got %h want %h", err_max, (MON ? 9'd1 : 9'd0)); end
    endtask

    task automatic test_error();
        logic [7:0]  va [2];
        logic [8:0]  vs [2];
        logic [15:0] vc [2];
        logic [8:0]  vm [2];
        va[0] = 8'h02; vs[0] = 9'h006; vc[0] = MON ? 16'd1 : 16'd0; vm[0] = MON ? 9'd2 : 9'd0;
        va[1] = 8'hFF; vs[1] = 9'h1FF; vc[1] = MON ? 16'd1 : 16'd0; vm[1] = MON ? 9'd2 : 9'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_a = va[i]; in_b = va[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_chk++; if (out_sum !== vs[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL error_sum[%0d]: got %h/%b want %h/1", i, out_sum, out_valid, vs[i]); end
            @(negedge clk);
            n_chk++; if (err_count !== vc[i]) begin n_fail++; $display("FAIL error_count[%0d]: got %h want %h", i, err_count, vc[i]); end
            n_chk++; if (err_max !== vm[i]) begin n_fail++; $display("FAIL error_max[%0d]: got %h want %h", i, err_max, vm[i]); end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int head = 0;
        int cyc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_chk++; if (out_valid !== 1'b1 || out_sum !== 9'h000) begin n_fail++; $display("FAIL bp_stall_hold[%0d]: got %h/%b want 000/1", c, out_sum, out_valid); end
            end
            in_a = idx[7:0]; in_b = 8'h00; in_valid = 1'b1;
            #1;
            n_chk++; if (in_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, (c < 2)); end
            if (in_ready) idx++;
        end
        // Drain with an irregular out_ready while the tail is still streaming in.
        while (head < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc % 3) != 2;
            if (out_valid) begin
                n_chk++; if (out_sum !== 9'(head)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", head, out_sum, 9'(head)); end
                if (out_ready) head++;
            end
            in_a = idx[7:0]; in_valid = (idx < 8);
            #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_chk++; if (head != 8) begin n_fail++; $display("FAIL bp_drain_timeout: got %0d results want 8", head); end
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        int acc = 0;
        @(negedge clk);
        err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_chk++; if (err_count !== 16'd0 || err_max !== 9'd0) begin n_fail++; $display("FAIL sat_preclear: got %h/%h want 0/0", err_count, err_max); end
        for (int n = 0; n < 65541; n++) begin
            if (n == 1000) begin
                n_chk++; if (err_count !== (MON ? 16'd998 : 16'd0)) begin n_fail++; $display("FAIL sat_midcount: got %0d want %0d", err_count, (MON ? 998 : 0)); end
            end
            in_a = 8'h02; in_b = 8'h02; in_valid = (acc < 65537);
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (err_count !== (MON ? 16'hFFFF : 16'h0)) begin n_fail++; $display("FAIL sat_count: got %h want %h", err_count, (MON ? 16'hFFFF : 16'h0)); end
        n_chk++; if (err_max !== (MON ? 9'd2 : 9'd0)) begin n_fail++; $display("FAIL sat_max: got %h want %h", err_max, (MON ? 9'd2 : 9'd0)); end
        // Clear coinciding with an erroneous delivery: clear wins.
        in_a = 8'h02; in_b = 8'h02; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_valid: got %b want 1", out_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %h want 0", err_count); end
        n_chk++; if (err_max !== 9'd0) begin n_fail++; $display("FAIL clr_max: got %h want 0", err_max); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        // Put something in the statistics first.
        @(negedge clk);
        in_a = 8'h02; in_b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (err_count !== (MON ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL rmid_pre_count: got %h want %h", err_count, (MON ? 16'd1 : 16'd0)); end
        // Two results in flight, consumer stalled.
        out_ready = 1'b0;
        in_a = 8'h11; in_b = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        in_a = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready_rst: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got %b want 0", out_valid); end
        n_chk++; if (err_count !== 16'd0 || err_max !== 9'd0) begin n_fail++; $display("FAIL rmid_stats: got %h/%h want 0/0", err_count, err_max); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rmid_stale: got %0d deliveries want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_error();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
